// File: rtl/wait_state_ctrl.sv
// Per-bus-cycle wait-state sequencer: programmed waits, then external-ready stretch with timeout.
// ready_o is registered and drops the clock after cyc_start_i; cfg writes apply from the next cycle start.
module wait_state_ctrl #(
  parameter logic [3:0] MEM_WAITS = 4'd0,
  parameter logic [3:0] IO_RST    = 4'd2,
  parameter logic [3:0] ROM_RST   = 4'd1,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       cyc_start_i,
  input  logic       cyc_end_i,
  input  logic       is_io_i,
  input  logic       is_rom_i,
  input  logic       ext_rdy_i,
  input  logic       cfg_we_i,
  input  logic [7:0] cfg_din_i,
  output logic [7:0] cfg_q_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic [3:0] wait_cnt_o,
  output logic       tmo_flag_o
);

  typedef enum logic [1:0] {IDLE, WAIT, EXTW, HOLD} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [3:0]  req_waits;
  logic [7:0]  tmo_cnt_inc;
  logic        launch;
  logic        tmo_set;

  // I/O takes priority over ROM; the register value before any same-clock write is used.
  assign req_waits   = is_io_i ? cfg_q[3:0] : (is_rom_i ? cfg_q[7:4] : MEM_WAITS);
  assign tmo_cnt_inc = tmo_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_set    = 1'b0;
    launch     = 1'b0;

    unique case (state_q)
      IDLE: launch = cyc_start_i;
      HOLD: begin
        if (cyc_start_i) begin
          launch = 1'b1;
        end else if (cyc_end_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cyc_end_i) begin
          state_d    = IDLE;
          ready_d    = 1'b1;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q <= 4'd1) begin
          wait_cnt_d = 4'd0;
          if (ext_rdy_i) begin
            state_d = HOLD;
            ready_d = 1'b1;
          end else begin
            state_d   = EXTW;
            tmo_cnt_d = 8'd0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      EXTW: begin
        if (cyc_end_i) begin
          state_d    = IDLE;
          ready_d    = 1'b1;
          wait_cnt_d = 4'd0;
        end else if (ext_rdy_i) begin
          state_d = HOLD;
          ready_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
          if (tmo_cnt_inc >= TIMEOUT) begin
            state_d = HOLD;
            ready_d = 1'b1;
            tmo_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (launch) begin
      if (req_waits != 4'd0) begin
        state_d    = WAIT;
        ready_d    = 1'b0;
        wait_cnt_d = req_waits;
      end else if (!ext_rdy_i) begin
        state_d   = EXTW;
        ready_d   = 1'b0;
        tmo_cnt_d = 8'd0;
      end else begin
        state_d = HOLD;
        ready_d = 1'b1;
      end
    end
  end

  // A timeout in the same clock as a config write keeps the flag set.
  assign tmo_flag_d = tmo_set | (tmo_flag_q & ~cfg_we_i);
  assign cfg_d      = cfg_we_i ? cfg_din_i : cfg_q;

  always_ff @(posedge clk_i or negedge clr_i) begin
    if (!clr_i) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      wait_cnt_q <= 4'd0;
      tmo_cnt_q  <= 8'd0;
      tmo_flag_q <= 1'b0;
      cfg_q      <= {ROM_RST, IO_RST};
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
      cfg_q      <= cfg_d;
    end
  end

  assign cfg_q_o    = cfg_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q == WAIT) || (state_q == EXTW);
  assign wait_cnt_o = wait_cnt_q;
  assign tmo_flag_o = tmo_flag_q;

endmodule

// File: tb/tb_wait_state_ctrl.sv
// Bench for wait_state_ctrl: stimulus queues the expected ready-low episode per bus cycle,
// a negedge monitor measures each episode and compares it against the queue.
module tb_wait_state_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       cyc_start, cyc_end, is_io, is_rom, ext_rdy, cfg_we;
  logic [7:0] cfg_din;
  logic [7:0] cfg_q_o;
  logic       ready_o, busy_o, tmo_flag_o;
  logic [3:0] wait_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   len;
    int   cnt;
    logic tmo;
  } exp_t;
  exp_t sb_q[$];

  wait_state_ctrl #(.TIMEOUT(8'd8)) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .cyc_start_i (cyc_start),
    .cyc_end_i   (cyc_end),
    .is_io_i     (is_io),
    .is_rom_i    (is_rom),
    .ext_rdy_i   (ext_rdy),
    .cfg_we_i    (cfg_we),
    .cfg_din_i   (cfg_din),
    .cfg_q_o     (cfg_q_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .wait_cnt_o  (wait_cnt_o),
    .tmo_flag_o  (tmo_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: an episode starts when cyc_start is seen and ends at the first sample with ready high.
  logic armed = 1'b0;
  logic first = 1'b0;
  int   ep_len, ep_blen, ep_cnt;
  exp_t e;

  always @(negedge clk) begin
    if (clr !== 1'b1) begin
      armed = 1'b0;
    end else begin
      if (armed) begin
        if (first) begin
          ep_cnt = int'(wait_cnt_o);
          first  = 1'b0;
        end
        if (busy_o) ep_blen++;
        if (!ready_o) begin
          ep_len++;
        end else begin
          armed = 1'b0;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got episode len %0d expected no episode", ep_len);
          end else begin
            e = sb_q.pop_front();
            check("ready_low_len", ep_len, e.len);
            check("busy_len", ep_blen, e.len);
            check("wait_cnt_first", ep_cnt, e.cnt);
            check("tmo_flag_at_release", int'(tmo_flag_o), int'(e.tmo));
          end
        end
      end
      if (cyc_start) begin
        armed   = 1'b1;
        first   = 1'b1;
        ep_len  = 0;
        ep_blen = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] din);
    cfg_we  = 1'b1;
    cfg_din = din;
    step();
    cfg_we  = 1'b0;
    check("cfg_q", int'(cfg_q_o), int'(din));
  endtask

  // ext_low: number of clock edges, counting the cyc_start edge, at which ext_rdy is sampled low.
  task automatic run_cyc(input logic io, input logic rom, input int ext_low,
                         input logic wr, input logic [7:0] din,
                         input int exp_len, input int exp_cnt, input logic exp_tmo);
    sb_q.push_back('{exp_len, exp_cnt, exp_tmo});
    cyc_start = 1'b1;
    is_io     = io;
    is_rom    = rom;
    ext_rdy   = (ext_low == 0);
    cfg_we    = wr;
    cfg_din   = din;
    step();
    cyc_start = 1'b0;
    is_io     = 1'b0;
    is_rom    = 1'b0;
    cfg_we    = 1'b0;
    for (int i = 1; i <= 40 && !ready_o; i++) begin
      ext_rdy = (i >= ext_low);
      step();
    end
    ext_rdy = 1'b1;
    cyc_end = 1'b1;
    step();
    cyc_end = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; cyc_start = 1'b0; cyc_end = 1'b0; is_io = 1'b0; is_rom = 1'b0;
    ext_rdy = 1'b1; cfg_we = 1'b0; cfg_din = 8'h00;
    #12;
    check("rst_ready", int'(ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_wait_cnt", int'(wait_cnt_o), 0);
    check("rst_tmo", int'(tmo_flag_o), 0);
    check("rst_cfg", int'(cfg_q_o), 8'h12);
    step();
    clr = 1'b1;
    step();

    // I/O cycle with reset config: two waits.
    run_cyc(1'b1, 1'b0, 0, 1'b0, 8'h00, 2, 2, 1'b0);

    // ROM waits 3, I/O waits 0.
    write_cfg(8'h30);
    run_cyc(1'b0, 1'b1, 0, 1'b0, 8'h00, 3, 3, 1'b0);
    run_cyc(1'b0, 1'b0, 0, 1'b0, 8'h00, 0, 0, 1'b0);
    run_cyc(1'b1, 1'b1, 0, 1'b0, 8'h00, 0, 0, 1'b0);

    // One programmed wait then five external-wait clocks.
    write_cfg(8'h31);
    run_cyc(1'b1, 1'b0, 6, 1'b0, 8'h00, 6, 1, 1'b0);

    // External ready stuck low: forced release after 8 EXTW clocks.
    run_cyc(1'b0, 1'b0, 1000, 1'b0, 8'h00, 8, 0, 1'b1);
    check("tmo_sticky", int'(tmo_flag_o), 1);
    write_cfg(8'h31);
    check("tmo_cleared", int'(tmo_flag_o), 0);

    // Maximum ROM wait, config rewritten mid-WAIT, then aborted by cyc_end.
    write_cfg(8'hF1);
    sb_q.push_back('{3, 15, 1'b0});
    cyc_start = 1'b1; is_rom = 1'b1; ext_rdy = 1'b1;
    step();
    cyc_start = 1'b0; is_rom = 1'b0;
    cfg_we = 1'b1; cfg_din = 8'h51;
    step();
    cfg_we = 1'b0;
    check("cnt_after_cfg_we", int'(wait_cnt_o), 14);
    step();
    cyc_end = 1'b1;
    step();
    cyc_end = 1'b0;
    check("abort_ready", int'(ready_o), 1);
    check("abort_wait_cnt", int'(wait_cnt_o), 0);
    check("abort_busy", int'(busy_o), 0);
    step();
    run_cyc(1'b0, 1'b1, 0, 1'b0, 8'h00, 5, 5, 1'b0);

    // Config write in the cyc_start clock: old I/O count (1) applies.
    run_cyc(1'b1, 1'b0, 0, 1'b1, 8'h53, 1, 1, 1'b0);
    check("cfg_same_clk", int'(cfg_q_o), 8'h53);
    run_cyc(1'b1, 1'b0, 0, 1'b0, 8'h00, 3, 3, 1'b0);

    // Asynchronous reset while in EXTW.
    cyc_start = 1'b1; ext_rdy = 1'b0;
    step();
    cyc_start = 1'b0;
    step();
    check("extw_busy", int'(busy_o), 1);
    #1;
    clr = 1'b0;
    #1;
    check("arst_ready", int'(ready_o), 1);
    check("arst_busy", int'(busy_o), 0);
    check("arst_cfg", int'(cfg_q_o), 8'h12);
    check("arst_wait_cnt", int'(wait_cnt_o), 0);
    ext_rdy = 1'b1;
    step();
    clr = 1'b1;
    step();
    run_cyc(1'b1, 1'b0, 0, 1'b0, 8'h00, 2, 2, 1'b0);

    step();
    check("sb_drained", sb_q.size(), 0);
    check("monitor_idle", int'(armed), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
